// File: rtl/ps2_scan_sequencer.sv
// PS/2 set-2 scan-code sequencer: strips E0/F0/E1 prefixes and
// emits one held key event per make/break code, with timeout recovery.
module ps2_scan_sequencer #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int TW          = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] keyCode,
    output logic       press,
    output logic       ext,
    output logic       evt_valid,
    output logic       busy,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic [2:0]    skip_cnt;
    logic [2:0]    skip_nx;

    logic is_e0;
    logic is_f0;
    logic is_e1;
    logic is_12;
    logic is_ign;
    logic expire;

    logic emit;
    logic emit_press;
    logic emit_ext;
    logic proto_err;
    logic err_inc;

    assign is_e0  = (byte_in == 8'hE0);
    assign is_f0  = (byte_in == 8'hF0);
    assign is_e1  = (byte_in == 8'hE1);
    assign is_12  = (byte_in == 8'h12);
    assign is_ign = (byte_in == 8'h00) || (byte_in == 8'hAA) ||
                    (byte_in == 8'hEE) || (byte_in == 8'hFA) ||
                    (byte_in == 8'hFC) || (byte_in == 8'hFE) ||
                    (byte_in == 8'hFF);

    // A byte on the expiry cycle takes priority over the timeout.
    assign expire = !byte_valid && (state != IDLE) &&
                    (timer == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            skip_cnt <= 3'd0;
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_nx;
        end
    end

    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        if (byte_valid) begin
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        is_e0: state_nx = EXT;
                        is_f0: state_nx = BRK;
                        is_e1: begin
                            state_nx = SKIP;
                            skip_nx  = 3'd7;
                        end
                        default: state_nx = IDLE;
                    endcase
                end
                EXT: begin
                    if (is_f0) state_nx = EXT_BRK;
                    else       state_nx = IDLE;
                end
                BRK:     state_nx = IDLE;
                EXT_BRK: state_nx = IDLE;
                SKIP: begin
                    skip_nx = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end else if (expire) begin
            state_nx = IDLE;
            skip_nx  = 3'd0;
        end
    end

    always_comb begin
        emit       = 1'b0;
        emit_press = 1'b0;
        emit_ext   = 1'b0;
        proto_err  = 1'b0;
        if (byte_valid) begin
            unique case (state)
                IDLE: begin
                    emit       = !(is_e0 || is_f0 || is_e1 || is_ign);
                    emit_press = 1'b1;
                end
                EXT: begin
                    proto_err  = is_e0 || is_e1;
                    emit       = !(is_e0 || is_e1 || is_f0 || is_12);
                    emit_press = 1'b1;
                    emit_ext   = 1'b1;
                end
                BRK: begin
                    proto_err = is_e0 || is_f0 || is_e1;
                    emit      = !(is_e0 || is_f0 || is_e1);
                end
                EXT_BRK: begin
                    proto_err = is_e0 || is_f0 || is_e1;
                    emit      = !(is_e0 || is_f0 || is_e1 || is_12);
                    emit_ext  = 1'b1;
                end
                SKIP: ;
                default: ;
            endcase
        end
    end

    assign err_inc = proto_err || expire;
    assign busy    = (state != IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            timer <= '0;
        end else if (byte_valid || expire || state == IDLE) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Key fields only move on an event so level samplers never see glitches.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            keyCode   <= 8'h00;
            press     <= 1'b0;
            ext       <= 1'b0;
            evt_valid <= 1'b0;
        end else begin
            evt_valid <= emit;
            if (emit) begin
                keyCode <= byte_in;
                press   <= emit_press;
                ext     <= emit_ext;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_cnt <= 8'h00;
        end else if (err_inc && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Bench for ps2_scan_sequencer: directed scenarios plus random bytes,
// checked every cycle against a sequence-level reference model.
module tb_ps2_scan_sequencer;

    localparam int TO = 20;

    logic       Clk;
    logic       Reset_n;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [7:0] keyCode;
    logic       press;
    logic       ext;
    logic       evt_valid;
    logic       busy;
    logic [7:0] err_cnt;

    int total;
    int bad;

    logic [7:0] m_seq[$];
    int         m_idle;
    logic [7:0] m_key;
    logic       m_press;
    logic       m_ext;
    logic       m_evt;
    int         m_err;
    int         n_evt;

    ps2_scan_sequencer #(.TIMEOUT_CYC(TO), .TW(16)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .keyCode   (keyCode),
        .press     (press),
        .ext       (ext),
        .evt_valid (evt_valid),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_seq.delete();
        m_idle  = 0;
        m_key   = 8'h00;
        m_press = 1'b0;
        m_ext   = 1'b0;
        m_evt   = 1'b0;
        m_err   = 0;
    endtask

    function automatic bit ignorable(input logic [7:0] b);
        return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
               b == 8'hFC || b == 8'hFE || b == 8'hFF;
    endfunction

    task automatic emit(input logic [7:0] b, input logic p, input logic e);
        m_key   = b;
        m_press = p;
        m_ext   = e;
        m_evt   = 1'b1;
        n_evt++;
    endtask

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    // Decide from the prefix bytes gathered so far what this byte means.
    task automatic take(input logic [7:0] b);
        bit pre_ext;
        bit pre_brk;
        if (m_seq.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) m_seq.push_back(b);
            else if (!ignorable(b)) emit(b, 1'b1, 1'b0);
        end else if (m_seq[0] == 8'hE1) begin
            m_seq.push_back(b);
            if (m_seq.size() == 8) m_seq.delete();
        end else begin
            pre_ext = (m_seq[0] == 8'hE0);
            pre_brk = (m_seq[m_seq.size()-1] == 8'hF0);
            if (b == 8'hE0 || b == 8'hE1) begin
                bump_err();
                m_seq.delete();
            end else if (b == 8'hF0) begin
                if (pre_ext && !pre_brk) m_seq.push_back(b);
                else begin
                    bump_err();
                    m_seq.delete();
                end
            end else if (b == 8'h12 && pre_ext) begin
                m_seq.delete();
            end else begin
                emit(b, !pre_brk, pre_ext);
                m_seq.delete();
            end
        end
    endtask

    task automatic m_step(input logic v, input logic [7:0] b);
        m_evt = 1'b0;
        if (v) begin
            m_idle = 0;
            take(b);
        end else if (m_seq.size() != 0) begin
            if (m_idle == TO - 1) begin
                m_seq.delete();
                m_idle = 0;
                bump_err();
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic cmp_all();
        chk("evt_valid", evt_valid, m_evt);
        chk("busy", busy, m_seq.size() != 0);
        chk("err_cnt", err_cnt, m_err);
        chk("keyCode", keyCode, m_key);
        chk("press", press, m_press);
        chk("ext", ext, m_ext);
    endtask

    task automatic cyc(input logic v, input logic [7:0] b);
        byte_valid = v;
        byte_in    = v ? b : 8'($urandom);
        @(posedge Clk);
        m_step(v, b);
        #1;
        byte_valid = 1'b0;
        cmp_all();
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        cyc(1'b1, b);
        for (int i = 0; i < gap; i++) cyc(1'b0, 8'h00);
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] pool[10];
        pool = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h1C,
                 8'h75, 8'h00, 8'hAA, 8'hFF, 8'h29};
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        return pool[$urandom_range(0, 9)];
    endfunction

    int ev0;
    int e0;

    initial begin
        total      = 0;
        bad        = 0;
        n_evt      = 0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        Reset_n    = 1'b0;
        m_reset();
        repeat (3) @(posedge Clk);
        #1;
        cmp_all();
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;

        // Reset in the middle of an extended sequence.
        send(8'h1C, 1);
        send(8'hE0, 0);
        #2 Reset_n = 1'b0;
        #1;
        m_reset();
        chk("rst_busy", busy, 0);
        chk("rst_key", keyCode, 8'h00);
        chk("rst_err", err_cnt, 0);
        cmp_all();
        @(negedge Clk);
        Reset_n = 1'b1;
        send(8'h1D, 0);
        chk("after_rst_evt", evt_valid, 1);
        chk("after_rst_key", keyCode, 8'h1D);
        cyc(1'b0, 8'h00);
        chk("evt_one_cycle", evt_valid, 0);

        // Make/break and extended sequences.
        ev0 = n_evt;
        send(8'h1C, 2);
        send(8'hF0, 2);
        send(8'h1C, 2);
        send(8'hE0, 1);
        send(8'h75, 1);
        send(8'hE0, 1);
        send(8'hF0, 1);
        send(8'h75, 1);
        chk("arrow_break_key", keyCode, 8'h75);
        chk("arrow_break_ext", {press, ext}, 2'b01);
        send(8'hE0, 0);
        send(8'h12, 1);
        chk("seq_events", n_evt - ev0, 4);

        // Pause sequence yields no events.
        ev0 = n_evt;
        send(8'hE1, 0);
        send(8'h14, 0);
        send(8'h77, 0);
        send(8'hE1, 0);
        send(8'hF0, 0);
        send(8'h14, 0);
        send(8'hF0, 0);
        chk("pause_busy", busy, 1);
        send(8'h77, 0);
        chk("pause_done", busy, 0);
        chk("pause_events", n_evt - ev0, 0);
        send(8'h29, 1);

        // Timeout after a lone break prefix, then byte on the expiry cycle.
        e0 = m_err;
        send(8'hF0, TO + 2);
        chk("timeout_err", err_cnt, e0 + 1);
        send(8'h23, 1);
        send(8'hF0, TO - 1);
        send(8'h1C, 1);
        chk("expiry_byte_err", err_cnt, e0 + 1);
        chk("expiry_byte_key", {keyCode, press}, {8'h1C, 1'b0});

        // Random traffic with gaps around the timeout boundary.
        for (int i = 0; i < 1500; i++) begin
            int g;
            g = ($urandom_range(0, 15) == 0) ? $urandom_range(TO - 2, TO + 1)
                                             : $urandom_range(0, 2);
            send(pick(), g);
        end

        // Saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            send(8'hF0, 0);
            send(8'hF0, 0);
        end
        chk("err_sat", err_cnt, 8'hFF);
        send(8'hE0, 0);
        send(8'hE0, 0);
        chk("err_hold", err_cnt, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
